pwrmgr_seq: RTL and testbench

//  Parametrised power sequencer between the board pins and the soc core. Holds the soc in reset

---
 rtl/pwrmgr_seq_pkg.sv | 20 ++
 rtl/pwrmgr_seq_if.sv | 28 ++
 rtl/pwrmgr_seq_timer.sv | 36 +++
 rtl/pwrmgr_seq.sv | 145 ++++++++++++++
 tb/tb_pwrmgr_seq.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/pwrmgr_seq_pkg.sv
// Shared types and helpers for the power sequencer.
package pwrmgr_seq_pkg;

    // One-hot sequencer states.
    typedef enum logic [3:0] {
        PmOff   = 4'b0001,
        PmArm   = 4'b0010,
        PmRun   = 4'b0100,
        PmDrain = 4'b1000
    } pm_state_e;

    // Level driven on gated pins while the soc is unpowered.
    localparam logic PmIdle = 1'b1;

    // Bits needed to hold 0..max_val, never less than one.
    function automatic int unsigned cnt_w(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/pwrmgr_seq_if.sv
// Pin/soc-side signal bundle of the power sequencer.
interface pwrmgr_seq_if #(
    parameter int unsigned NUM_CH   = 1,
    parameter int unsigned NUM_WAKE = 1,
    parameter int unsigned CNT_W    = 8
);
    logic [NUM_WAKE-1:0] wake_n;
    logic                poweroff_rq;
    logic [NUM_CH-1:0]   soc_tx;
    logic [NUM_CH-1:0]   soc_rts;
    logic [NUM_CH-1:0]   uart_tx;
    logic [NUM_CH-1:0]   uart_rts;
    logic                soc_resetn;
    logic                running;
    logic [CNT_W-1:0]    boot_count;

    // Environment side: drives wake/soc signals, observes pins and status.
    modport master (
        output wake_n, poweroff_rq, soc_tx, soc_rts,
        input  uart_tx, uart_rts, soc_resetn, running, boot_count
    );

    // Sequencer side.
    modport slave (
        input  wake_n, poweroff_rq, soc_tx, soc_rts,
        output uart_tx, uart_rts, soc_resetn, running, boot_count
    );
endinterface

// File: rtl/pwrmgr_seq_timer.sv
// Loadable down-counter with zero flag; stops at zero.
module pwrmgr_seq_timer
    import pwrmgr_seq_pkg::*;
#(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);
    logic [Width-1:0] cnt_d, cnt_q;

    // Load has priority over decrement.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/pwrmgr_seq.sv
// Power sequencer: debounced wake, post-poweroff drain, cooldown, pin gating, boot counter.
module pwrmgr_seq
    import pwrmgr_seq_pkg::*;
#(
    parameter int unsigned         NUM_CH       = 1,
    parameter int unsigned         NUM_WAKE     = 1,
    parameter logic [NUM_WAKE-1:0] WAKE_MASK    = '1,
    parameter int unsigned         DEBOUNCE     = 1,
    parameter int unsigned         DRAIN_CYCLES = 0,
    parameter int unsigned         MIN_OFF      = 0,
    parameter int unsigned         CNT_W        = 8
) (
    input logic          clk,
    input logic          resetn,
    pwrmgr_seq_if.slave  bus
);
    if (DEBOUNCE < 1) begin : gen_bad_debounce
        $error("pwrmgr_seq: DEBOUNCE must be at least 1");
    end

    localparam int unsigned DbW    = cnt_w(DEBOUNCE - 1);
    localparam int unsigned DrMax  = (DRAIN_CYCLES > 0) ? DRAIN_CYCLES - 1 : 0;
    localparam int unsigned DrW    = cnt_w(DrMax);
    localparam int unsigned OffW   = cnt_w(MIN_OFF);
    localparam logic [DbW-1:0]  DbLast = DbW'(DEBOUNCE - 1);
    localparam logic [DrW-1:0]  DrLoad = DrW'(DrMax);
    localparam logic [OffW-1:0] OffLoad = OffW'(MIN_OFF);
    localparam logic DrNone = (DRAIN_CYCLES == 0);

    pm_state_e        state_d, state_q;
    logic [DbW-1:0]   db_cnt_d, db_cnt_q;
    logic [CNT_W-1:0] boot_count_d, boot_count_q;
    logic             wake;
    logic             dr_load, dr_dec, dr_zero;
    logic             off_load, off_dec, off_zero;
    logic             boot_inc;
    logic             st_run, st_drain;

    assign wake = |(~bus.wake_n & WAKE_MASK);

    pwrmgr_seq_timer #(.Width(DrW)) u_drain_timer (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (dr_load),
        .load_val_i (DrLoad),
        .dec_i      (dr_dec),
        .zero_o     (dr_zero)
    );

    pwrmgr_seq_timer #(.Width(OffW)) u_off_timer (
        .clk        (clk),
        .resetn     (resetn),
        .load_i     (off_load),
        .load_val_i (OffLoad),
        .dec_i      (off_dec),
        .zero_o     (off_zero)
    );

    // Next-state, timer controls and debounce counting.
    always_comb begin
        state_d  = state_q;
        db_cnt_d = db_cnt_q;
        dr_load  = 1'b0;
        dr_dec   = 1'b0;
        off_load = 1'b0;
        off_dec  = 1'b0;
        boot_inc = 1'b0;
        unique case (state_q)
            PmOff: begin
                if (!off_zero) begin
                    off_dec = 1'b1;  // cooldown: wake ignored
                end else if (wake) begin
                    if (DEBOUNCE == 1) begin
                        state_d  = PmRun;
                        boot_inc = 1'b1;
                    end else begin
                        state_d  = PmArm;
                        db_cnt_d = DbW'(1);
                    end
                end
            end
            PmArm: begin
                if (!wake) begin
                    state_d = PmOff;
                end else if (db_cnt_q == DbLast) begin
                    state_d  = PmRun;
                    boot_inc = 1'b1;
                end else begin
                    db_cnt_d = db_cnt_q + DbW'(1);
                end
            end
            PmRun: begin
                if (bus.poweroff_rq) begin
                    if (DrNone) begin
                        state_d  = PmOff;
                        off_load = 1'b1;
                    end else begin
                        state_d = PmDrain;
                        dr_load = 1'b1;
                    end
                end
            end
            PmDrain: begin
                if (dr_zero) begin
                    state_d  = PmOff;
                    off_load = 1'b1;
                end else begin
                    dr_dec = 1'b1;
                end
            end
            default: state_d = PmOff;
        endcase
    end

    // Saturating power-up counter.
    always_comb begin
        boot_count_d = boot_count_q;
        if (boot_inc && (boot_count_q != '1)) begin
            boot_count_d = boot_count_q + CNT_W'(1);
        end
    end

    // State and counter registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= PmOff;
            db_cnt_q     <= '0;
            boot_count_q <= '0;
        end else begin
            state_q      <= state_d;
            db_cnt_q     <= db_cnt_d;
            boot_count_q <= boot_count_d;
        end
    end

    assign st_run   = (state_q == PmRun);
    assign st_drain = (state_q == PmDrain);

    // With no drain phase the soc is cut off in the same cycle the request rises.
    assign bus.soc_resetn = resetn & (st_drain | (st_run & ~(bus.poweroff_rq & DrNone)));
    assign bus.running    = st_run;
    assign bus.boot_count = boot_count_q;
    assign bus.uart_tx    = (st_run | st_drain) ? bus.soc_tx  : {NUM_CH{PmIdle}};
    assign bus.uart_rts   = (st_run | st_drain) ? bus.soc_rts : {NUM_CH{PmIdle}};
endmodule

// File: tb/tb_pwrmgr_seq.sv
// Directed bench for pwrmgr_seq: vector table plus multi-cycle corner sequences.
module tb_pwrmgr_seq;
    logic clk = 1'b0;
    logic resetn;

    pwrmgr_seq_if #(.NUM_CH(2), .NUM_WAKE(1), .CNT_W(2)) bus ();

    pwrmgr_seq #(
        .NUM_CH       (2),
        .NUM_WAKE     (1),
        .WAKE_MASK    (1'b1),
        .DEBOUNCE     (4),
        .DRAIN_CYCLES (8),
        .MIN_OFF      (16),
        .CNT_W        (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // exp = {running, soc_resetn, uart_tx[1:0], uart_rts[1:0], boot_count[1:0]}
    typedef struct packed {
        logic       wake_n;
        logic       rq;
        logic [1:0] tx;
        logic [1:0] rts;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[20];
    int   total = 0;
    int   bad   = 0;
    int   first;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [7:0] outs();
        return {bus.running, bus.soc_resetn, bus.uart_tx, bus.uart_rts, bus.boot_count};
    endfunction

    // From RUN with wake held: request poweroff, count edges until RUN again.
    task automatic power_cycle(input logic [1:0] exp_bc, input string tag);
        int f;
        f = 0;
        bus.poweroff_rq = 1'b1;
        step();
        bus.poweroff_rq = 1'b0;
        if (bus.running === 1'b1) f = 1;
        for (int e = 2; e <= 40 && f == 0; e++) begin
            step();
            if (bus.running === 1'b1) f = e;
        end
        chk({tag, "_edges"}, f, 29);
        chk({tag, "_bc"}, bus.boot_count, exp_bc);
    endtask

    initial begin
        resetn          = 1'b0;
        bus.wake_n      = 1'b1;
        bus.poweroff_rq = 1'b0;
        bus.soc_tx      = 2'b00;
        bus.soc_rts     = 2'b00;

        // Table: boot abort on 3rd sample, full boot, drain with ignored request, OFF entry.
        vecs[0]  = '{1'b1, 1'b0, 2'b01, 2'b10, 8'b0_0_11_11_00};
        vecs[1]  = '{1'b0, 1'b0, 2'b01, 2'b10, 8'b0_0_11_11_00};
        vecs[2]  = '{1'b0, 1'b0, 2'b01, 2'b10, 8'b0_0_11_11_00};
        vecs[3]  = '{1'b0, 1'b0, 2'b01, 2'b10, 8'b0_0_11_11_00};
        vecs[4]  = '{1'b1, 1'b0, 2'b01, 2'b10, 8'b0_0_11_11_00};
        vecs[5]  = '{1'b1, 1'b0, 2'b01, 2'b10, 8'b0_0_11_11_00};
        vecs[6]  = '{1'b0, 1'b0, 2'b01, 2'b10, 8'b0_0_11_11_00};
        vecs[7]  = '{1'b0, 1'b0, 2'b01, 2'b10, 8'b0_0_11_11_00};
        vecs[8]  = '{1'b0, 1'b0, 2'b01, 2'b10, 8'b0_0_11_11_00};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 2'b01, 8'b1_1_10_01_01};
        vecs[10] = '{1'b1, 1'b0, 2'b01, 2'b11, 8'b1_1_01_11_01};
        vecs[11] = '{1'b1, 1'b1, 2'b11, 2'b00, 8'b0_1_11_00_01};
        vecs[12] = '{1'b0, 1'b0, 2'b00, 2'b11, 8'b0_1_00_11_01};
        vecs[13] = '{1'b0, 1'b1, 2'b01, 2'b01, 8'b0_1_01_01_01};
        vecs[14] = '{1'b0, 1'b0, 2'b10, 2'b10, 8'b0_1_10_10_01};
        vecs[15] = '{1'b0, 1'b0, 2'b00, 2'b01, 8'b0_1_00_01_01};
        vecs[16] = '{1'b0, 1'b0, 2'b10, 2'b10, 8'b0_1_10_10_01};
        vecs[17] = '{1'b0, 1'b0, 2'b01, 2'b00, 8'b0_1_01_00_01};
        vecs[18] = '{1'b0, 1'b0, 2'b10, 2'b10, 8'b0_1_10_10_01};
        vecs[19] = '{1'b0, 1'b0, 2'b00, 2'b00, 8'b0_0_11_11_01};

        // Reset state, with a clock edge while reset is held.
        bus.soc_tx  = 2'b01;
        bus.soc_rts = 2'b10;
        step();
        chk("rst_outs", outs(), 8'b0_0_11_11_00);
        resetn = 1'b1;

        for (int i = 0; i < 20; i++) begin
            bus.wake_n      = vecs[i].wake_n;
            bus.poweroff_rq = vecs[i].rq;
            bus.soc_tx      = vecs[i].tx;
            bus.soc_rts     = vecs[i].rts;
            step();
            chk($sformatf("vec%0d", i), outs(), vecs[i].exp);
        end

        // Cooldown: wake held since DRAIN; RUN exactly 16+4 edges after OFF entry.
        bus.soc_tx = 2'b01;
        for (int e = 1; e <= 20; e++) begin
            step();
            chk($sformatf("cool_run%0d", e), bus.running, (e == 20) ? 1 : 0);
            if (e == 19) chk("cool_tx_gated", bus.uart_tx, 2'b11);
        end
        chk("cool_bc", bus.boot_count, 2'd2);
        chk("cool_tx_pass", bus.uart_tx, 2'b01);

        // Saturation of boot_count.
        power_cycle(2'd3, "cyc3");
        power_cycle(2'd3, "cyc4");
        repeat (3) step();
        chk("sat_hold", bus.boot_count, 2'd3);

        // Async reset in the middle of DRAIN.
        bus.soc_tx      = 2'b00;
        bus.soc_rts     = 2'b00;
        bus.poweroff_rq = 1'b1;
        step();
        bus.poweroff_rq = 1'b0;
        repeat ($urandom_range(0, 6)) step();
        chk("drain_srn", bus.soc_resetn, 1'b1);
        chk("drain_tx", bus.uart_tx, 2'b00);
        #3 resetn = 1'b0;
        #1;
        chk("mid_rst_outs", outs(), 8'b0_0_11_11_00);
        #2 resetn = 1'b1;
        first = 0;
        for (int e = 1; e <= 12 && first == 0; e++) begin
            step();
            if (bus.running === 1'b1) first = e;
        end
        chk("post_rst_edges", first, 4);
        chk("post_rst_bc", bus.boot_count, 2'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
